// File: rtl/kr_sweep_sequencer.sv
// Knight-rider sweep timing source: divides clk into a periodic tick and bounces a
// single one-hot position back and forth across N_LEDS channels.
module kr_sweep_sequencer #(
  parameter int N_LEDS     = 8,
  parameter int TICK_DIV   = 1024,
  parameter int STEP_TICKS = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         enable,
  output logic                                         tick,
  output logic [N_LEDS-1:0]                            select,
  output logic [((N_LEDS > 1) ? $clog2(N_LEDS) : 1)-1:0] pos,
  output logic                                         dir
);

  localparam int PosW  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int StepW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  localparam logic [PosW-1:0]  PosMax  = PosW'(N_LEDS - 1);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
  localparam logic [StepW-1:0] StepMax = StepW'(STEP_TICKS - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StUp   = 2'd1;
  localparam logic [1:0] StDown = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PosW-1:0]  pos_q, pos_d;
  logic [TickW-1:0] presc_q, presc_d;
  logic [StepW-1:0] step_q, step_d;
  logic             tick_int;

  assign tick_int = (state_q != StIdle) && (presc_q == TickMax);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    presc_d = presc_q;
    step_d  = step_q;
    if (!enable || (state_q == StIdle)) begin
      // Idle and the first enabled edge both leave every counter at zero.
      state_d = enable ? StUp : StIdle;
      pos_d   = '0;
      presc_d = '0;
      step_d  = '0;
    end else begin
      presc_d = tick_int ? '0 : presc_q + 1'b1;
      if (tick_int) begin
        step_d = (step_q == StepMax) ? '0 : step_q + 1'b1;
        // A single channel never moves and never turns around.
        if ((step_q == StepMax) && (N_LEDS > 1)) begin
          if (state_q == StUp) begin
            if (pos_q == PosMax) begin
              state_d = StDown;
              pos_d   = pos_q - 1'b1;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              state_d = StUp;
              pos_d   = pos_q + 1'b1;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pos_q   <= '0;
      presc_q <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    select = '0;
    if (state_q != StIdle) begin
      select[pos_q] = 1'b1;
    end
  end

  assign tick = tick_int;
  assign pos  = pos_q;
  assign dir  = (state_q == StDown);

endmodule
